// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART transmit scheduler
// Purpose: holds the UART byte width, the grant-source constants and the
//          scheduler FSM state encoding used by uart_tx_sched and uts_fifo.
// Ports:   none (package)
package uart_pkg;

  localparam int UART_W = 8;

  // Grant source. Also stored as the round-robin "last granted" pointer.
  localparam logic GNT_ECHO = 1'b0;
  localparam logic GNT_LOC  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2,
    S_GAP     = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uts_fifo.sv
// rtl/uts_fifo.sv - synchronous byte FIFO buffering echo bytes
// Purpose: DEPTH x UART_W synchronous FIFO with first-word fall-through read.
//          A push on a full FIFO is accepted only when a pop happens in the
//          same cycle; a pop on an empty FIFO is ignored.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   push  in   write din this cycle
//   pop   in   discard head entry this cycle
//   din   in   byte to write
//   dout  out  head entry (valid while empty=0)
//   full  out  FIFO holds DEPTH entries
//   empty out  FIFO holds no entries
//   level out  occupancy 0..DEPTH, updates the cycle after push/pop
module uts_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [UART_W-1:0]        din,
  output logic [UART_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

  logic [UART_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_MAX);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // Full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - schedules one UART transmitter between echo and local bytes
// Purpose: buffers received bytes in an echo FIFO and arbitrates the transmitter
//          between the echo FIFO and a local byte source (round-robin or local
//          strict priority), with an optional idle gap between bytes.
// Optional feature: define UTS_OVF_CNT_EN to add the ovf_cnt output.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx_valid   in   received byte strobe
//   rx_data    in   received byte
//   rx_err     in   framing error qualifier for rx_valid (byte discarded)
//   loc_req    in   local byte pending, held with loc_data until loc_ack
//   loc_data   in   local byte
//   loc_ack    out  local byte issued (aligned with tx_start)
//   tx_start   out  transmitter load strobe
//   tx_data    out  byte to transmit, held until the next issue
//   tx_busy    in   transmitter busy
//   fifo_level out  echo FIFO occupancy
//   ovf        out  sticky echo byte drop flag
//   ovf_cnt    out  saturating dropped-byte count (UTS_OVF_CNT_EN only)
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int LOC_PRIO = 0,
  parameter int TX_GAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [UART_W-1:0]      rx_data,
  input  logic                   rx_err,
  input  logic                   loc_req,
  input  logic [UART_W-1:0]      loc_data,
  output logic                   loc_ack,
  output logic                   tx_start,
  output logic [UART_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf
`ifdef UTS_OVF_CNT_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  // Gap counter is loaded with TX_GAP-1 so S_GAP lasts exactly TX_GAP cycles.
  localparam logic [7:0] GAP_LOAD = (TX_GAP > 0) ? 8'(TX_GAP - 1) : 8'd0;

  tx_state_t         state;
  tx_state_t         state_n;
  logic              grant;
  logic              gnt_src;
  logic              last_src;
  logic [7:0]        gap_cnt;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [UART_W-1:0] fifo_dout;
  logic              drop;

  assign fifo_push = rx_valid & ~rx_err;
  assign fifo_pop  = grant & (gnt_src == GNT_ECHO);
  assign drop      = fifo_push & fifo_full & ~fifo_pop;

  uts_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    gnt_src = GNT_ECHO;
    case (state)
      S_IDLE: begin
        if (!tx_busy && (!fifo_empty || loc_req)) begin
          grant   = 1'b1;
          state_n = S_WAIT_HI;
          if (LOC_PRIO != 0) begin
            gnt_src = loc_req ? GNT_LOC : GNT_ECHO;
          end else if (!fifo_empty && loc_req) begin
            // Tie: hand the transmitter to whoever was not served last.
            gnt_src = (last_src == GNT_LOC) ? GNT_ECHO : GNT_LOC;
          end else begin
            gnt_src = loc_req ? GNT_LOC : GNT_ECHO;
          end
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_n = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          state_n = (TX_GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'd0) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      loc_ack  <= 1'b0;
      tx_data  <= '0;
      last_src <= GNT_LOC;
      gap_cnt  <= 8'd0;
      ovf      <= 1'b0;
    end else begin
      tx_start <= grant;
      loc_ack  <= grant & (gnt_src == GNT_LOC);
      if (grant) begin
        tx_data  <= (gnt_src == GNT_LOC) ? loc_data : fifo_dout;
        last_src <= gnt_src;
      end
      if (state == S_WAIT_LO && state_n == S_GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == S_GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef UTS_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 8'd0;
    end else if (drop && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;

  // dut0: round-robin, no gap. dut1: local priority, TX_GAP=4.
  logic       loc_req0, loc_req1;
  logic [7:0] loc_data0, loc_data1;
  logic       loc_ack0, loc_ack1;
  logic       tx_start0, tx_start1;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_busy0, tx_busy1;
  logic [4:0] fifo_level0, fifo_level1;
  logic       ovf0, ovf1;
`ifdef UTS_OVF_CNT_EN
  logic [7:0] ovf_cnt0, ovf_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_len = 10;
  logic busy_force = 1'b0;
  int bcnt0 = 0;
  int bcnt1 = 0;
  logic [7:0] txq0[$], txq1[$];
  logic       ackq0[$], ackq1[$];
  int         tq0[$], tq1[$];

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH(16), .LOC_PRIO(0), .TX_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .loc_req(loc_req0), .loc_data(loc_data0), .loc_ack(loc_ack0),
    .tx_start(tx_start0), .tx_data(tx_data0), .tx_busy(tx_busy0),
    .fifo_level(fifo_level0), .ovf(ovf0)
`ifdef UTS_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt0)
`endif
  );

  uart_tx_sched #(.DEPTH(16), .LOC_PRIO(1), .TX_GAP(4)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .loc_req(loc_req1), .loc_data(loc_data1), .loc_ack(loc_ack1),
    .tx_start(tx_start1), .tx_data(tx_data1), .tx_busy(tx_busy1),
    .fifo_level(fifo_level1), .ovf(ovf1)
`ifdef UTS_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt1)
`endif
  );

  // Transmitter model: busy for busy_len cycles after each tx_start; not reset by rst.
  assign tx_busy0 = busy_force | (bcnt0 != 0);
  assign tx_busy1 = busy_force | (bcnt1 != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start0) begin
      txq0.push_back(tx_data0); ackq0.push_back(loc_ack0); tq0.push_back(cyc);
      bcnt0 = busy_len;
    end else if (bcnt0 > 0) bcnt0 = bcnt0 - 1;
    if (tx_start1) begin
      txq1.push_back(tx_data1); ackq1.push_back(loc_ack1); tq1.push_back(cyc);
      bcnt1 = busy_len;
    end else if (bcnt1 > 0) bcnt1 = bcnt1 - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    loc_req0 = 1'b0; loc_req1 = 1'b0; loc_data0 = 8'h00; loc_data1 = 8'h00;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic clear_q();
    txq0.delete(); ackq0.delete(); tq0.delete();
    txq1.delete(); ackq1.delete(); tq1.delete();
  endtask

  task automatic send_rx(input logic [7:0] d, input logic err);
    rx_valid = 1'b1; rx_data = d; rx_err = err;
    @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    loc_req0 = 1'b0; loc_req1 = 1'b0; loc_data0 = 8'h00; loc_data1 = 8'h00;

    // Reset state
    do_reset();
    chk("rst_loc_ack", loc_ack0, 0);
    chk("rst_tx_start", tx_start0, 0);
    chk("rst_tx_data", tx_data0, 8'h00);
    chk("rst_fifo_level", fifo_level0, 0);
    chk("rst_ovf", ovf0, 0);

    // Single echo: tx_start two cycles after rx_valid
    clear_q();
    busy_len = 10;
    c0 = cyc;
    send_rx(8'h41, 1'b0);
    for (int i = 0; i < 20 && txq0.size() < 1; i++) @(negedge clk);
    chk("echo_count", txq0.size(), 1);
    if (txq0.size() >= 1) begin
      chk("echo_data", txq0[0], 8'h41);
      chk("echo_latency", tq0[0] - c0, 2);
      chk("echo_no_ack", ackq0[0], 0);
    end
    ticks(30);
    chk("echo_single_issue", txq0.size(), 1);

    // rx_err discards the byte
    do_reset();
    clear_q();
    send_rx(8'hFF, 1'b1);
    ticks(6);
    chk("err_level", fifo_level0, 0);
    chk("err_ovf", ovf0, 0);
    chk("err_no_tx", txq0.size(), 0);

    // Burst of 20 into a held-busy transmitter: 16 kept, 4 dropped
    do_reset();
    busy_force = 1'b1;
    clear_q();
    for (int i = 0; i < 20; i++) send_rx(8'(i), 1'b0);
    chk("burst_level_full", fifo_level0, 16);
    chk("burst_ovf", ovf0, 1);
`ifdef UTS_OVF_CNT_EN
    chk("burst_ovf_cnt", ovf_cnt0, 4);
`endif
    chk("burst_no_tx_while_busy", txq0.size(), 0);
    busy_len = 3;
    busy_force = 1'b0;
    for (int i = 0; i < 400 && txq0.size() < 16; i++) @(negedge clk);
    ticks(20);
    chk("burst_count", txq0.size(), 16);
    for (int i = 0; i < 16 && i < txq0.size(); i++) chk($sformatf("burst_byte%0d", i), txq0[i], 8'(i));
    chk("burst_level_empty", fifo_level0, 0);
    chk("burst_ovf_sticky", ovf0, 1);
    for (int i = 0; i < 200 && txq1.size() < 16; i++) @(negedge clk);

    // Tie between echo and local on both arbitration modes
    do_reset();
    busy_force = 1'b1;
    ticks(20);
    send_rx(8'hA0, 1'b0);
    send_rx(8'hA1, 1'b0);
    clear_q();
    busy_len = 4;
    loc_req0 = 1'b1; loc_data0 = 8'h55;
    loc_req1 = 1'b1; loc_data1 = 8'h55;
    busy_force = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (loc_ack0) begin
        if (loc_data0 == 8'h55) loc_data0 = 8'h56; else loc_req0 = 1'b0;
      end
      if (loc_ack1) begin
        if (loc_data1 == 8'h55) loc_data1 = 8'h56; else loc_req1 = 1'b0;
      end
      if (txq0.size() >= 4 && txq1.size() >= 4) break;
    end
    ticks(30);
    chk("rr_count", txq0.size(), 4);
    chk("prio_count", txq1.size(), 4);
    if (txq0.size() == 4) begin
      chk("rr_tx0", txq0[0], 8'hA0); chk("rr_tx1", txq0[1], 8'h55);
      chk("rr_tx2", txq0[2], 8'hA1); chk("rr_tx3", txq0[3], 8'h56);
      chk("rr_ack", {ackq0[0], ackq0[1], ackq0[2], ackq0[3]}, 4'b0101);
      chk("rr_spacing", tq0[1] - tq0[0], busy_len + 2);
    end
    if (txq1.size() == 4) begin
      chk("prio_tx0", txq1[0], 8'h55); chk("prio_tx1", txq1[1], 8'h56);
      chk("prio_tx2", txq1[2], 8'hA0); chk("prio_tx3", txq1[3], 8'hA1);
      chk("prio_ack", {ackq1[0], ackq1[1], ackq1[2], ackq1[3]}, 4'b1100);
      chk("gap4_spacing", tq1[1] - tq1[0], busy_len + 6);
      chk("gap4_spacing_echo", tq1[3] - tq1[2], busy_len + 6);
    end

    // Reset in S_WAIT_LO with three bytes queued
    do_reset();
    ticks(10);
    clear_q();
    busy_len = 20;
    for (int i = 0; i < 4; i++) send_rx(8'hB0 + 8'(i), 1'b0);
    for (int i = 0; i < 20 && txq1.size() < 1; i++) @(negedge clk);
    ticks(3);
    chk("mid_first_issued", txq1.size(), 1);
    chk("mid_level_before", fifo_level1, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_level_after", fifo_level1, 0);
    chk("mid_tx_start_after", tx_start1, 0);
    ticks(60);
    chk("mid_no_more_tx", txq1.size(), 1);
    chk("mid_no_more_tx_rr", txq0.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
